// File: rtl/display_pkg.sv
// Shared display types and geometry: framebuffer FSM states and the default
// scan geometry reused by display_driver benches.
package display_pkg;

  localparam int ROWS        = 8;
  localparam int COLUMNS     = 32;
  localparam int PIXEL_WIDTH = 24;

  localparam int ROW_W       = $clog2(ROWS);
  localparam int COL_W       = $clog2(COLUMNS);
  localparam int BANK_ADDR_W = ROW_W + COL_W;
  localparam int MEM_ADDR_W  = BANK_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    FLIP_WAIT
  } fb_state_t;

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port pixel store: one write port, one registered read port.
module framebuffer_ram #(
  parameter int depth = 512,
  parameter int width = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [width-1:0]         wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [width-1:0]         rd_data
);

  logic [width-1:0] mem [depth];

  // NOTE: the array itself is never reset; a reset loop over every word would
  // stop the tools from mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/framebuffer_controller.sv
// Double-buffered pixel store with tear-free flip scheduling and hardware
// back-bank clear, sitting between the frame renderer and display_driver.
module framebuffer_controller
  import display_pkg::*;
#(
  parameter int rows       = ROWS,
  parameter int columns    = COLUMNS,
  parameter int pixelwidth = PIXEL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(rows)-1:0]    drv_row,
  input  logic [$clog2(columns)-1:0] drv_column,
  output logic [pixelwidth-1:0]      drv_pixel,
  input  logic                       drv_frame_complete,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(rows)-1:0]    wr_row,
  input  logic [$clog2(columns)-1:0] wr_column,
  input  logic [pixelwidth-1:0]      wr_data,
  input  logic                       clr_req,
  input  logic                       flip_req,
  output logic                       flip_ack,
  output logic                       busy,
  output logic                       front_bank
);

  localparam int cnt_w  = $clog2(rows) + $clog2(columns);
  localparam int addr_w = cnt_w + 1;
  localparam int depth  = 2 * rows * columns;

  fb_state_t        state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             flip_pend_q, flip_pend_d;
  logic             front_q, front_d;
  logic             flip_ack_q;
  logic             swap;

  logic              wr_fire;
  logic              mem_we;
  logic [addr_w-1:0] mem_waddr;
  logic [addr_w-1:0] mem_raddr;
  logic [pixelwidth-1:0] mem_wdata;

  assign wr_ready = (state_q == IDLE) && !rst;
  assign wr_fire  = wr_valid && wr_ready;
  assign busy     = !rst && ((state_q != IDLE) || flip_pend_q);
  assign flip_ack = flip_ack_q && !rst;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flip_pend_d = flip_pend_q;
    front_d     = front_q;
    swap        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d     = CLEAR;
          cnt_d       = '0;
          flip_pend_d = flip_req;
        end else if (flip_req) begin
          state_d = FLIP_WAIT;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (flip_req) begin
          flip_pend_d = 1'b1;
        end
        // A flip requested on the final clear word still counts as pending.
        if (&cnt_q) begin
          state_d = (flip_pend_q || flip_req) ? FLIP_WAIT : IDLE;
        end
      end
      FLIP_WAIT: begin
        if (drv_frame_complete) begin
          swap        = 1'b1;
          front_d     = ~front_q;
          flip_pend_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      flip_pend_q <= 1'b0;
      front_q     <= 1'b0;
      flip_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flip_pend_q <= flip_pend_d;
      front_q     <= front_d;
      flip_ack_q  <= swap;
    end
  end

  assign front_bank = front_q;

  // The renderer and the clear engine both target the bank not on display.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~front_q, wr_row, wr_column};
    mem_wdata = wr_data;
    if (state_q == CLEAR) begin
      mem_we    = !rst;
      mem_waddr = {~front_q, cnt_q};
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  // Bank bit is sampled alongside the address, so a swap never splits a read.
  assign mem_raddr = {front_q, drv_row, drv_column};

  framebuffer_ram #(
    .depth (depth),
    .width (pixelwidth)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_addr (mem_raddr),
    .rd_data (drv_pixel)
  );

endmodule
